// File: rtl/uart_rx_if.sv
// Serial-receive side of a UART: oversampling tick and line in, received byte and status out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_done_tick;
  logic                 frame_err;

  modport master (output baud_tick, rx, input data_out, rx_done_tick, frame_err);
  modport slave  (input baud_tick, rx, output data_out, rx_done_tick, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver, oversampled by baud_tick; samples each bit at its midpoint.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OS_TICKS  = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OS_TICKS);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OS_TICKS/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OS_TICKS - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n, data_q, data_n;
  logic                 err_q, err_n, done_q, done_n;
  logic                 rx_meta, rx_sync;

  // Synchronizer resets to the idle-line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      data_q   <= data_n;
      err_q    <= err_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    data_n  = data_q;
    err_n   = err_q;
    done_n  = 1'b0;
    case (state)
      IDLE: if (!rx_sync) begin
        state_n = START;
        tick_n  = '0;
      end
      START: if (bus.baud_tick) begin
        if (tick_cnt == HALF_M1) begin
          // A start bit that is gone by mid-bit was noise.
          if (!rx_sync) begin
            state_n = DATA;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end
      DATA: if (bus.baud_tick) begin
        if (tick_cnt == FULL_M1) begin
          tick_n  = '0;
          shift_n = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_cnt == LAST) state_n = STOP;
          else                 bit_n   = bit_cnt + BW'(1);
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end
      STOP: if (bus.baud_tick) begin
        if (tick_cnt == FULL_M1) begin
          data_n  = shift_q;
          err_n   = ~rx_sync;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_out     = data_q;
  assign bus.frame_err    = err_q;
  assign bus.rx_done_tick = done_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, back-to-back, glitch, bad stop, mid-frame reset, tick jitter.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   pulses = 0;
  bit   dbl = 1'b0;
  bit   prev_done = 1'b0;
  bit   jitter = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_err[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.DATA_BITS(8), .OS_TICKS(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Tick generator: fixed 4-clk period, or random 1..5 clk gaps when jitter is set.
  initial begin
    int cnt = 0;
    int gap = 4;
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= gap) begin
        bus.baud_tick = 1'b1;
        cnt = 0;
        gap = jitter ? int'($urandom_range(1, 5)) : 4;
      end else begin
        bus.baud_tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.rx_done_tick) begin
      if (prev_done) dbl = 1'b1;
      pulses++;
      cap_data.push_back(bus.data_out);
      cap_err.push_back(bus.frame_err);
    end
    prev_done = bus.rx_done_tick;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, required end before 3ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk); #1;
      if (bus.baud_tick) k++;
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    bus.rx = v;
    wait_ticks(n);
  endtask

  // Bad stop bit is held low past its midpoint, then the line recovers.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(b[i], 16);
    if (stop_ok) send_bit(1'b1, 16);
    else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 4);
    end
  endtask

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(bus.data_out), 32'h00);
    chk("rst_err", 32'(bus.frame_err), 32'h0);
    chk("rst_done", 32'(bus.rx_done_tick), 32'h0);
    rst = 1'b0;
    send_bit(1'b1, 20);
    chk("idle_pulses", 32'(pulses), 32'd0);

    send_frame(8'h55, 1'b1);
    send_bit(1'b1, 20);
    chk("f55_pulses", 32'(pulses), 32'd1);
    chk("f55_data", 32'(cap_data[0]), 32'h55);
    chk("f55_err", 32'(cap_err[0]), 32'h0);
    send_bit(1'b1, 40);
    chk("f55_hold", 32'(bus.data_out), 32'h55);

    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_bit(1'b1, 20);
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_data0", 32'(cap_data[1]), 32'hA3);
    chk("b2b_err0", 32'(cap_err[1]), 32'h0);
    chk("b2b_data1", 32'(cap_data[2]), 32'h0F);
    chk("b2b_err1", 32'(cap_err[2]), 32'h0);

    send_bit(1'b0, 4);
    send_bit(1'b1, 30);
    chk("glitch_pulses", 32'(pulses), 32'd3);
    chk("glitch_data", 32'(bus.data_out), 32'h0F);

    send_frame(8'hC8, 1'b0);
    send_bit(1'b1, 30);
    chk("badstop_pulses", 32'(pulses), 32'd4);
    chk("badstop_data", 32'(cap_data[3]), 32'hC8);
    chk("badstop_err", 32'(cap_err[3]), 32'h1);
    chk("badstop_hold", 32'(bus.frame_err), 32'h1);
    send_frame(8'h12, 1'b1);
    send_bit(1'b1, 20);
    chk("f12_pulses", 32'(pulses), 32'd5);
    chk("f12_data", 32'(bus.data_out), 32'h12);
    chk("f12_err", 32'(bus.frame_err), 32'h0);

    // 0xFF aborted by reset in the middle of data bit 4.
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 6);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_data", 32'(bus.data_out), 32'h00);
    chk("abort_err", 32'(bus.frame_err), 32'h0);
    send_bit(1'b1, 10);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 20);
    chk("abort_pulses", 32'(pulses), 32'd5);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1, 20);
    chk("f3c_pulses", 32'(pulses), 32'd6);
    chk("f3c_data", 32'(bus.data_out), 32'h3C);
    chk("f3c_err", 32'(bus.frame_err), 32'h0);

    jitter = 1'b1;
    send_bit(1'b1, 10);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, 20);
    chk("jit_pulses", 32'(pulses), 32'd7);
    chk("jit_data", 32'(bus.data_out), 32'h81);
    chk("jit_err", 32'(bus.frame_err), 32'h0);
    chk("pulse_width", 32'(dbl), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, the number of data bits per frame (8 in all scenarios below).
REQ-002 SHALL provide parameter OS_TICKS, default 16, the number of baud_tick pulses per bit period (even, >=4).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_tick  input  1  one-clk-wide pulse at OS_TICKS x baud rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_BITS  last received byte, registered.
REQ-008 SHALL have port rx_done_tick  output  1  one-clk pulse when data_out is updated.
REQ-009 SHALL have port frame_err  output  1  stop-bit status of the last frame, registered.

Function
REQ-010 SHALL receive 8N1 frames: 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high), no parity.
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-012 SHALL implement the FSM states IDLE, START, DATA and STOP, with a tick counter (tick_cnt) and a bit counter (bit_cnt).
REQ-013 In IDLE, on rx_sync==0, the FSM SHALL clear tick_cnt and go to START; baud_tick is not required for this transition.
REQ-014 In START, on each baud_tick, tick_cnt SHALL increment; at tick_cnt==OS_TICKS/2-1 (mid start bit) the FSM SHALL act as follows:
  - rx_sync==0: clear tick_cnt and bit_cnt, go to DATA.
  - rx_sync==1: treat as a glitch, return to IDLE with no output change.
REQ-015 In DATA, on each baud_tick, tick_cnt SHALL increment; at tick_cnt==OS_TICKS-1 (mid data bit) the FSM SHALL:
  - shift rx_sync into the shift-register MSB, shifting right;
  - clear tick_cnt;
  - go to STOP if bit_cnt==DATA_BITS-1, otherwise increment bit_cnt.
REQ-016 In STOP, on each baud_tick, tick_cnt SHALL increment; at tick_cnt==OS_TICKS-1 (mid stop bit) the block SHALL:
  - load data_out from the shift register;
  - set frame_err to ~rx_sync;
  - pulse rx_done_tick;
  - go to IDLE.
REQ-017 rx_done_tick SHALL be high for exactly one clk cycle: the cycle after the baud_tick that sampled the stop bit.
REQ-018 data_out and frame_err SHALL hold their values between rx_done_tick pulses.
REQ-019 A frame with a bad stop bit SHALL still deliver data_out, with frame_err=1.
REQ-020 If rx_sync is low on return to IDLE (break, or back-to-back start bit), a new frame SHALL begin on the next clk.
REQ-021 Cycles without baud_tick SHALL leave tick_cnt, bit_cnt and the shift register unchanged.
REQ-022 Transitions on rx between sample points SHALL have no effect outside IDLE.
REQ-023 End-to-end latency SHALL be 2 clk (synchronizer) from the rx edge at the stop-bit midpoint to the sampling baud_tick, plus 1 clk to rx_done_tick.
REQ-024 Counter widths SHALL be sized with clog2 of OS_TICKS and DATA_BITS, and counters SHALL never wrap inside a state.

Reset
REQ-025 On rst=1 at a clk edge, the block SHALL reset as follows:
  - state = IDLE;
  - tick_cnt, bit_cnt, shift register and data_out = 0;
  - rx_done_tick = 0 and frame_err = 0;
  - both synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick, and reception SHALL restart only on a new falling edge after rst deasserts.
REQ-027 rst SHALL take priority over baud_tick and rx in the same cycle.

Verification
REQ-028 Byte 0x55 at 16x ticks, stop=1 -> one rx_done_tick, data_out=0x55, frame_err=0.
REQ-029 Bytes 0xA3 then 0x0F back-to-back, with no idle between the stop bit and the next start bit -> two pulses with data_out 0xA3 then 0x0F, both with frame_err=0.
REQ-030 rx low for 4 baud ticks then high (glitch) -> FSM returns to IDLE, no rx_done_tick, data_out unchanged.
REQ-031 Byte 0xC8 with stop bit driven 0 -> rx_done_tick, data_out=0xC8, frame_err=1; a following good frame 0x12 -> frame_err=0.
REQ-032 rst pulsed during data bit 4 of 0xFF, followed by a clean 0x3C frame -> no pulse for the aborted frame; data_out=0x3C, frame_err=0.
REQ-033 baud_tick gaps of 1-5 clks with random jitter, and frame 0x81 -> data_out=0x81, exactly one pulse.
